rom_q_rd_ctrl: RTL
==================

// Module: rom_q_rd_ctrl
// PURPOSE
//  Read controller for the DTFAG twiddle ROM pair, directly upstream of the ROM-Q
//  decompose stage. Per FFT stage it walks the twiddle exponent sequence and splits
//  each exponent into high/low table indices. It drives word addresses to ROM banks
//  B0 (high table) and B1 (low table), each word packing two entries as HA|LA.
//  It emits the HA/LA half-selects and a valid, delay-aligned to ROM read latency.
// PARAMETERS
//  EXP_W    16  twiddle exponent width (N = 2**EXP_W = 65536)
//  CNT_W    12  log2(twiddles per stage pass); pass length LEN = 2**CNT_W
//  RADIX_W  4   log2(radix); exponent step = 1 << (RADIX_W*stage)
//  STAGE_W  2   width of stage select
//  ROM_LAT  2   ROM read latency in enabled cycles (>=1)
// PORTS
//  clk        in   1          clock, rising edge
//  rst        in   1          asynchronous reset, active high
//  start      in   1          pulse: begin one pass (sampled only in IDLE)
//  stage_i    in   STAGE_W    FFT stage for the pass, latched on accepted start
//  en         in   1          global advance enable; 0 freezes block and ROMs
//  rom_ce     out  1          ROM clock enable, = en
//  ROM_B0_A   out  EXP_W/2-1  B0 word address = eH[EXP_W/2-1:1]
//  ROM_B1_A   out  EXP_W/2-1  B1 word address = eL[EXP_W/2-1:1]
//  B0_sel     out  1          1 -> use ROM_B0_HA_out, 0 -> ROM_B0_LA_out (aligned)
//  B1_sel     out  1          1 -> use ROM_B1_HA_out, 0 -> ROM_B1_LA_out (aligned)
//  tw_valid   out  1          ROM data + selects valid this cycle
//  busy       out  1          high from accepted start until done
//  done       out  1          one-cycle pulse with last tw_valid
// BEHAVIOUR
//  - Reset: state=IDLE; n, exp, addresses, sels, tw_valid, busy, done, delay line = 0.
//  - States: IDLE -> RUN on start&en; RUN -> DRAIN after n=LEN-1 issued;
//    DRAIN -> IDLE when last entry exits delay line (done pulses that cycle).
//  - start ignored when not IDLE or en=0; stage_i sampled only on accept.
//  - Accept at edge t: ROM_B*_A for n=0 registered, visible in cycle t+1.
//  - Each enabled RUN cycle issues one exponent: exp_n = (n << (RADIX_W*stage)) mod 2**EXP_W,
//    computed as accumulator exp += step, wrap-around modulo 2**EXP_W (carry dropped).
//  - eH = exp[EXP_W-1:EXP_W/2], eL = exp[EXP_W/2-1:0]; sel = LSB of eH/eL, addr = rest.
//  - Valid/sel delay line is ROM_LAT enabled cycles deep: tw_valid for issue n is high
//    exactly ROM_LAT enabled cycles after its address is visible.
//  - en=0: counters, state, addresses, delay line, tw_valid, done all hold; rom_ce=0.
//  - busy=1 in RUN and DRAIN; done pulses for one enabled cycle then busy drops next edge.
//  - Exactly LEN tw_valid cycles per pass; back-to-back start accepted in cycle after done.
//  - Addresses hold last issued value in DRAIN/IDLE (don't-care, no tw_valid).
//  - rst mid-pass: immediate return to reset values; no done, partial pass discarded.
// TESTING
//  1. Reset then stage_i=0, start, en=1 -> LEN=4096 tw_valid; exp 0,1,2..; first valid
//     ROM_LAT+1 cycles after start edge; done on 4096th valid; busy low next cycle.
//  2. stage_i=3 (step 4096): exp 0,0x1000,..,0xF000,0x0000 wrap; ROM_B1_A=0, B1_sel=0 always,
//     ROM_B0_A = 0,8,16..120,0 with B0_sel=0.
//  3. stage_i=1 (step 16): n=16 -> exp=0x0100 -> ROM_B0_A=0,B0_sel=1,ROM_B1_A=0,B1_sel=0;
//     n=15 -> exp 0x00F0 -> ROM_B1_A=0x78, B1_sel=0.
//  4. Toggle en=0 for 3 cycles mid-RUN and during DRAIN -> all outputs frozen; total
//     valid count still 4096, sequence unchanged, no duplicates.
//  5. start pulsed while busy -> ignored; stage_i changes mid-pass -> no effect.
//  6. Assert rst at n=100 -> all outputs 0 within the cycle, IDLE; new start runs clean pass.

Source files
------------

// File: rtl/rom_q_rd_ctrl.sv
// rom_q_rd_ctrl: twiddle ROM read controller for the DTFAG ROM pair.
// Walks the exponent sequence for one FFT stage pass and splits each exponent
// into high/low table indices. It drives word addresses to banks B0 (high
// table) and B1 (low table) and emits the half selects and a valid, both
// aligned to the ROM read latency.
//
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   start            pulse to begin a pass; honoured only in IDLE with en=1
//   stage_i          FFT stage, latched when start is accepted
//   en               global advance enable; 0 freezes the block and the ROMs
//   rom_ce           ROM clock enable (follows en)
//   ROM_B0_A         B0 word address (high exponent half without its LSB)
//   ROM_B1_A         B1 word address (low exponent half without its LSB)
//   B0_sel, B1_sel   1 selects the HA half of the word, 0 the LA half
//   tw_valid         ROM data and selects are valid this cycle
//   busy             pass in progress (RUN or DRAIN)
//   done             one-cycle pulse together with the last tw_valid
module rom_q_rd_ctrl #(
    parameter int EXP_W   = 16,
    parameter int CNT_W   = 12,
    parameter int RADIX_W = 4,
    parameter int STAGE_W = 2,
    parameter int ROM_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [STAGE_W-1:0]   stage_i,
    input  logic                 en,
    output logic                 rom_ce,
    output logic [EXP_W/2-2:0]   ROM_B0_A,
    output logic [EXP_W/2-2:0]   ROM_B1_A,
    output logic                 B0_sel,
    output logic                 B1_sel,
    output logic                 tw_valid,
    output logic                 busy,
    output logic                 done
);

    localparam int HALF = EXP_W / 2;
    localparam int LEN  = 2 ** CNT_W;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]         state;
    logic [CNT_W-1:0]   n_q;
    logic [EXP_W-1:0]   exp_q;
    logic [EXP_W-1:0]   step_q;
    logic [HALF-2:0]    b0a_q;
    logic [HALF-2:0]    b1a_q;
    logic               hsel_q;
    logic               lsel_q;
    logic               iss_v;
    logic               iss_last;

    // Delay line: one slot per enabled cycle of ROM latency.
    logic [ROM_LAT-1:0] pv;
    logic [ROM_LAT-1:0] ph;
    logic [ROM_LAT-1:0] pl;
    logic [ROM_LAT-1:0] plast;

    logic               accept;
    logic               last_issue;
    logic [EXP_W-1:0]   step_in;

    // Step is 1 << (RADIX_W*stage); shifts past the exponent width wrap to 0.
    function automatic logic [EXP_W-1:0] step_of(input logic [STAGE_W-1:0] s);
        int sh;
        sh = RADIX_W * int'(s);
        if (sh >= EXP_W) begin
            return '0;
        end
        return EXP_W'(1) << sh;
    endfunction

    assign step_in    = step_of(stage_i);
    assign accept     = (state == IDLE) && start && en;
    assign last_issue = (n_q == CNT_W'(LEN - 1));

    // Main FSM, exponent accumulator and address registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            n_q      <= '0;
            exp_q    <= '0;
            step_q   <= '0;
            b0a_q    <= '0;
            b1a_q    <= '0;
            hsel_q   <= 1'b0;
            lsel_q   <= 1'b0;
            iss_v    <= 1'b0;
            iss_last <= 1'b0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // n=0 always has exponent 0; accumulator
                        // is preloaded with exponent 1.
                        state    <= RUN;
                        n_q      <= '0;
                        step_q   <= step_in;
                        exp_q    <= step_in;
                        b0a_q    <= '0;
                        b1a_q    <= '0;
                        hsel_q   <= 1'b0;
                        lsel_q   <= 1'b0;
                        iss_v    <= 1'b1;
                        iss_last <= 1'b0;
                    end
                end
                RUN: begin
                    if (last_issue) begin
                        // Addresses hold their last value.
                        state    <= DRAIN;
                        iss_v    <= 1'b0;
                        iss_last <= 1'b0;
                    end else begin
                        n_q      <= n_q + 1'b1;
                        exp_q    <= exp_q + step_q;
                        b0a_q    <= exp_q[EXP_W-1:HALF+1];
                        hsel_q   <= exp_q[HALF];
                        b1a_q    <= exp_q[HALF-1:1];
                        lsel_q   <= exp_q[0];
                        iss_v    <= 1'b1;
                        iss_last <= (n_q == CNT_W'(LEN - 2));
                    end
                end
                DRAIN: begin
                    if (done) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Valid/select delay line, advancing only on enabled cycles so it
    // stays in step with the ROM pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pv    <= '0;
            ph    <= '0;
            pl    <= '0;
            plast <= '0;
        end else if (en) begin
            pv[0]    <= iss_v;
            ph[0]    <= hsel_q;
            pl[0]    <= lsel_q;
            plast[0] <= iss_v & iss_last;
            for (int i = 1; i < ROM_LAT; i++) begin
                pv[i]    <= pv[i-1];
                ph[i]    <= ph[i-1];
                pl[i]    <= pl[i-1];
                plast[i] <= plast[i-1];
            end
        end
    end

    assign rom_ce   = en;
    assign ROM_B0_A = b0a_q;
    assign ROM_B1_A = b1a_q;
    assign B0_sel   = ph[ROM_LAT-1];
    assign B1_sel   = pl[ROM_LAT-1];
    assign tw_valid = pv[ROM_LAT-1];
    assign done     = plast[ROM_LAT-1];
    assign busy     = (state != IDLE);

endmodule
